// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: CHANNELS PWM outputs driven from one shared period counter, each with a
// double-buffered duty register. Defining PWM_CENTER_EN adds a `center` input for up/down counting.
module pwm_multi_gen #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                enable,
    input  logic [WIDTH-1:0]    period,
    input  logic                wr_en,
    input  logic [CH_BITS-1:0]  wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
`ifdef PWM_CENTER_EN
    input  logic                center,
`endif
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_end
);
    localparam logic [CH_BITS:0] CH_LIMIT = (CH_BITS + 1)'(CHANNELS);

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    period_act_q, period_act_d;
    logic [WIDTH-1:0]    shadow_q   [CHANNELS];
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d, cmp;
    logic                period_end_q, period_end_d;
    logic                boundary, load, wr_ok;
    logic                edge_boundary;
    logic [WIDTH-1:0]    edge_cnt;

    assign wr_ok         = wr_en && ({1'b0, wr_ch} < CH_LIMIT);
    assign edge_boundary = (cnt_q == period_act_q);
    assign edge_cnt      = edge_boundary ? '0 : cnt_q + 1'b1;

`ifdef PWM_CENTER_EN
    logic dir_q, dir_d;  // 0 = counting up

    always_comb begin
        dir_d    = 1'b0;
        cnt_d    = '0;
        boundary = 1'b0;
        if (enable) begin
            if (center) begin
                boundary = (cnt_q == '0) && !dir_q;
                dir_d    = dir_q;
                if (period_act_q == '0) begin
                    cnt_d = '0;
                    dir_d = 1'b0;
                end else if (!dir_q && (cnt_q != period_act_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Arriving at 0 already faces up, so 0 is never revisited on the way down.
                    cnt_d = cnt_q - 1'b1;
                    dir_d = (cnt_q != WIDTH'(1));
                end
            end else begin
                boundary = edge_boundary;
                cnt_d    = edge_cnt;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) dir_q <= 1'b0;
        else     dir_q <= dir_d;
    end
`else
    always_comb begin
        cnt_d    = '0;
        boundary = 1'b0;
        if (enable) begin
            boundary = edge_boundary;
            cnt_d    = edge_cnt;
        end
    end
`endif

    // While parked, the active registers track their sources so the first period is current.
    always_comb begin
        period_act_d = period_act_q;
        period_end_d = 1'b0;
        load         = 1'b0;
        pwm_d        = '0;
        if (!enable) begin
            period_act_d = period;
            load         = 1'b1;
        end else begin
            period_end_d = boundary;
            pwm_d        = cmp;
            if (boundary) begin
                period_act_d = period;
                load         = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign cmp[gi] = (cnt_q < duty_act_q[gi]);

            // Boundary loads the pre-write shadow value when a write lands on the same edge.
            always_ff @(posedge clk_in or posedge rst) begin
                if (rst) begin
                    shadow_q[gi]   <= '0;
                    duty_act_q[gi] <= '0;
                end else begin
                    if (wr_ok && (wr_ch == CH_BITS'(gi))) shadow_q[gi] <= wr_duty;
                    if (load) duty_act_q[gi] <= shadow_q[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            period_act_q <= '0;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_act_q <= period_act_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm_out    = pwm_q;
    assign period_end = period_end_q;
endmodule
